// File: rtl/bench_pkg.sv
// Shared definitions for the benchmark harness.
//   bench_state_t : harness FSM states
//   popcount      : number of set bits in an up-to-8-lane vector
//   cycles_for    : run length in clock cycles for a given clock rate and duration
package bench_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bench_state_t;

  localparam int unsigned MAX_LANES = 8;
  localparam int unsigned SEC_W     = 10;

  function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  function automatic logic [63:0] cycles_for(input logic [63:0] hz, input logic [63:0] s);
    return hz * s;
  endfunction

endpackage

// File: rtl/bench_timer.sv
// Run-length timer for the benchmark harness.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   clear_i      : zero the divider and run-cycle counter (new run accepted)
//   enable_i     : high while the harness is in RUN
//   sec_tick_o   : high during every CLK_HZ-th enabled cycle
//   last_cycle_o : high during the final enabled cycle of the run
module bench_timer
  import bench_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 12_000_000,
  parameter int unsigned BENCHMARKSECONDS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic sec_tick_o,
  output logic last_cycle_o
);

  localparam logic [63:0] CYCLES = cycles_for(64'(CLK_HZ), 64'(BENCHMARKSECONDS));
  localparam int CYC_W = $clog2(CYCLES + 64'd1);
  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CYCLES - 64'd1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_HZ - 1);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [DIV_W-1:0] div_q, div_d;

  assign sec_tick_o   = enable_i && (div_q == LAST_DIV);
  assign last_cycle_o = enable_i && (cyc_q == LAST_CYC);

  always_comb begin
    cyc_d = cyc_q;
    div_d = div_q;
    if (clear_i) begin
      cyc_d = '0;
      div_d = '0;
    end else if (enable_i) begin
      // The run counter parks on its final value so it can never wrap.
      if (!last_cycle_o) cyc_d = cyc_q + CYC_W'(1);
      div_d = sec_tick_o ? '0 : div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      div_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/bench_harness.sv
// Benchmark harness: keeps NUM_LANES hash cores busy for CLK_HZ*BENCHMARKSECONDS
// cycles, counts completions (saturating), drains in-flight work, then holds
// the result until the next start.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : level request, honoured only in IDLE or DONE
//   core_start  : one-cycle start pulse per lane
//   core_done   : one-cycle completion pulse per lane
//   busy / done : RUN-or-DRAIN / DONE indicators
//   hash_count  : completions counted during RUN
//   elapsed_s   : whole seconds elapsed in the current/last run
//   proto_err   : sticky, completion seen on a lane with nothing in flight
module bench_harness
  import bench_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 12_000_000,
  parameter int unsigned BENCHMARKSECONDS = 10,
  parameter int unsigned NUM_LANES        = 1,
  parameter int unsigned COUNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [NUM_LANES-1:0] core_start,
  input  logic [NUM_LANES-1:0] core_done,
  output logic                 busy,
  output logic                 done,
  output logic [COUNT_W-1:0]   hash_count,
  output logic [SEC_W-1:0]     elapsed_s,
  output logic                 proto_err
);

  if (BENCHMARKSECONDS < 1 || BENCHMARKSECONDS > 600) begin : g_bad_seconds
    $fatal(1, "bench_harness: BENCHMARKSECONDS must be 1..600");
  end
  if (CLK_HZ < 1) begin : g_bad_hz
    $fatal(1, "bench_harness: CLK_HZ must be >= 1");
  end
  if (NUM_LANES < 1 || NUM_LANES > 8) begin : g_bad_lanes
    $fatal(1, "bench_harness: NUM_LANES must be 1..8");
  end
  if (COUNT_W < 8 || COUNT_W > 48) begin : g_bad_count_w
    $fatal(1, "bench_harness: COUNT_W must be 8..48");
  end

  bench_state_t           state_q, state_d;
  logic [NUM_LANES-1:0]   inflight_q, inflight_d;
  logic [NUM_LANES-1:0]   core_start_q, core_start_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic [SEC_W-1:0]       elapsed_q, elapsed_d;
  logic                   perr_q, perr_d;
  logic                   busy_q, done_q;

  logic                   accept, run_en, sec_tick, last_cycle;
  logic [NUM_LANES-1:0]   hit;
  logic [MAX_LANES-1:0]   hit_wide;
  logic [COUNT_W:0]       sum;
  logic [COUNT_W-1:0]     count_sat;

  assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign run_en   = (state_q == ST_RUN);
  assign hit      = core_done & inflight_q;
  assign hit_wide = MAX_LANES'(hit);
  // One spare bit catches the carry; any carry pins the count at all-ones.
  assign sum       = {1'b0, count_q} + (COUNT_W+1)'(popcount(hit_wide));
  assign count_sat = sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];

  bench_timer #(
    .CLK_HZ           (CLK_HZ),
    .BENCHMARKSECONDS (BENCHMARKSECONDS)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (accept),
    .enable_i     (run_en),
    .sec_tick_o   (sec_tick),
    .last_cycle_o (last_cycle)
  );

  always_comb begin
    state_d      = state_q;
    inflight_d   = inflight_q;
    core_start_d = '0;
    count_d      = count_q;
    elapsed_d    = elapsed_q;
    perr_d       = perr_q | (|(core_done & ~inflight_q));
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          inflight_d   = '1;
          core_start_d = '1;
          count_d      = '0;
          elapsed_d    = '0;
          perr_d       = 1'b0;
        end
      end
      ST_RUN: begin
        count_d = count_sat;
        if (sec_tick) elapsed_d = elapsed_q + SEC_W'(1);
        if (last_cycle) begin
          inflight_d = inflight_q & ~core_done;
          state_d    = ST_DRAIN;
        end else begin
          // Idle lanes and lanes finishing now are (re)started; every lane
          // is therefore in flight for the rest of the run.
          core_start_d = ~inflight_q | hit;
          inflight_d   = '1;
        end
      end
      ST_DRAIN: begin
        inflight_d = inflight_q & ~core_done;
        if (inflight_d == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      inflight_q   <= '0;
      core_start_q <= '0;
      count_q      <= '0;
      elapsed_q    <= '0;
      perr_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      core_start_q <= core_start_d;
      count_q      <= count_d;
      elapsed_q    <= elapsed_d;
      perr_q       <= perr_d;
      busy_q       <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign hash_count = count_q;
  assign elapsed_s  = elapsed_q;
  assign proto_err  = perr_q;

endmodule
